// File: rtl/alu_result_demux_if.sv
// Handshake bundle between the ALU result stage and its NOUT destination channels.
// slave is the demux side; master is the upstream/consumer side that drives it.
interface alu_result_demux_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
);
  localparam int NOUT = 2**SEL_W;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SEL_W-1:0]      in_sel;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic [15:0]           xfer_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, xfer_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, xfer_cnt
  );
endinterface

// File: rtl/alu_result_demux.sv
// 1-to-NOUT registered result demux, one cycle latency, one holding register per channel.
// Backpressure: only the selected channel gates in_ready; a drained slot reloads with no bubble.
module alu_result_demux #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_demux_if.slave bus
);
  localparam int NOUT = 2**SEL_W;

  logic [NOUT-1:0]            out_valid_q, out_valid_d;
  logic [NOUT-1:0][WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]                xfer_cnt_q, xfer_cnt_d;
  logic                       in_ready;
  logic                       accept;

  // rst_n is folded in so the upstream sees no readiness during an asynchronous reset.
  assign in_ready = rst_n && (!out_valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    xfer_cnt_d  = xfer_cnt_q;
    for (int i = 0; i < NOUT; i++) begin
      if (accept && (bus.in_sel == SEL_W'(i))) begin
        out_data_d[i]  = bus.in_data;
        out_valid_d[i] = 1'b1;
      end else if (out_valid_q[i] && bus.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
    if (accept) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: directed vector table, reset/wrap sequences,
// and random traffic scored against per-channel queues of accepted words.
module tb_alu_result_demux;
  localparam int WIDTH = 32;
  localparam int SEL_W = 2;
  localparam int NOUT  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_result_demux_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_result_demux #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] dat;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    int          ch;
    logic [31:0] exp_dat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] q[NOUT][$];
  int          mcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ch_data(input int ch);
    return bus.out_data[ch*WIDTH +: WIDTH];
  endfunction

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [31:0] dat,
                       input logic [3:0] ordy);
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = dat;
    bus.out_ready = ordy;
  endtask

  // One random cycle; the model holds every accepted but undelivered word per channel.
  task automatic rand_cycle();
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    iv   = ($urandom_range(0, 9) < 7);
    sel  = 2'($urandom_range(0, 3));
    ordy = 4'($urandom_range(0, 15));
    drive(iv, sel, $urandom, ordy);
    #1;
    for (int i = 0; i < NOUT; i++) exp_vld[i] = (q[i].size() != 0);
    exp_rdy = (q[sel].size() == 0) || ordy[sel];
    chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("rnd_out_valid", 32'(bus.out_valid), 32'(exp_vld));
    chk("rnd_xfer_cnt", 32'(bus.xfer_cnt), 32'(mcnt[15:0]));
    for (int i = 0; i < NOUT; i++) begin
      if (q[i].size() != 0 && ordy[i]) begin
        chk($sformatf("rnd_data_ch%0d", i), ch_data(i), q[i][0]);
        void'(q[i].pop_front());
      end
    end
    if (iv && exp_rdy) begin
      q[sel].push_back(bus.in_data);
      mcnt++;
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mcnt   = 0;
    rst_n  = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 4'h0);

    //            iv    sel   dat            ordy   rdy   vld      ch  dat            cnt
    tbl[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'b0100, 2, 32'hDEADBEEF, 16'd1};
    tbl[1]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'b0000, 2, 32'hDEADBEEF, 16'd1};
    tbl[2]  = '{1'b1, 2'd1, 32'h11,       4'hD, 1'b1, 4'b0010, 1, 32'h11,       16'd2};
    tbl[3]  = '{1'b1, 2'd1, 32'h22,       4'hD, 1'b0, 4'b0010, 1, 32'h11,       16'd2};
    tbl[4]  = '{1'b1, 2'd3, 32'h33,       4'hD, 1'b1, 4'b1010, 3, 32'h33,       16'd3};
    tbl[5]  = '{1'b1, 2'd1, 32'h22,       4'hF, 1'b1, 4'b0010, 1, 32'h22,       16'd4};
    tbl[6]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'b0000, 1, 32'h22,       16'd4};
    tbl[7]  = '{1'b1, 2'd0, 32'hA,        4'h0, 1'b1, 4'b0001, 0, 32'hA,        16'd5};
    tbl[8]  = '{1'b1, 2'd0, 32'hB,        4'h1, 1'b1, 4'b0001, 0, 32'hB,        16'd6};
    tbl[9]  = '{1'b0, 2'd0, 32'hC,        4'h0, 1'b0, 4'b0001, 0, 32'hB,        16'd6};
    tbl[10] = '{1'b0, 2'd2, 32'hD,        4'h0, 1'b1, 4'b0001, 0, 32'hB,        16'd6};
    tbl[11] = '{1'b0, 2'd0, 32'hE,        4'h1, 1'b1, 4'b0000, 0, 32'hB,        16'd6};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data_ch0", ch_data(0), 32'h0);
    chk("rst_out_data_ch3", ch_data(3), 32'h0);
    chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].iv, tbl[r].sel, tbl[r].dat, tbl[r].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", r), 32'(bus.in_ready), 32'(tbl[r].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].exp_vld));
      chk($sformatf("vec%0d_out_data", r), ch_data(tbl[r].ch), tbl[r].exp_dat);
      chk($sformatf("vec%0d_xfer_cnt", r), 32'(bus.xfer_cnt), 32'(tbl[r].exp_cnt));
    end

    // Fill every channel with consumers stalled, then reset between edges.
    for (int i = 0; i < NOUT; i++) begin
      drive(1'b1, 2'(i), 32'h100 + 32'(i), 4'h0);
      tick();
    end
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    chk("fill_out_valid", 32'(bus.out_valid), 32'hF);
    chk("fill_xfer_cnt", 32'(bus.xfer_cnt), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_out_data_ch1", ch_data(1), 32'h0);
    chk("midrst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst2_out_valid", 32'(bus.out_valid), 32'h0);
    chk("postrst2_in_ready", 32'(bus.in_ready), 32'h1);
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    tick();
    chk("postrst2_no_stale", 32'(bus.out_valid), 32'h0);

    for (int n = 0; n < 65535; n++) begin
      drive(1'b1, 2'(n), 32'(n), 4'hF);
      tick();
    end
    chk("wrap_pre_cnt", 32'(bus.xfer_cnt), 32'hFFFF);
    drive(1'b1, 2'd1, 32'h5A5A, 4'hF);
    #1;
    chk("wrap_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("wrap_cnt", 32'(bus.xfer_cnt), 32'h0);
    chk("wrap_data_ch1", ch_data(1), 32'h5A5A);
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    tick();
    chk("wrap_drained", 32'(bus.out_valid), 32'h0);

    mcnt = 0;
    for (int c = 0; c < 10000; c++) rand_cycle();
    drive(1'b0, 2'd0, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
